// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int OVF_CLR_BIT  = 3;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  // A push into a full FIFO still lands when the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-attached 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports
// FIFO/FSM state and a sticky overflow flag; read data is registered.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   status;

  logic          push_req, stat_wr, drop;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;
  logic          unused_bits;

  assign unused_bits = ^{bus_addr[29:1], bus_data_w[31:8], bus_mask_w[3:1]};

  assign push_req = sel && bus_mask_w[0] && (bus_addr[0] == REG_TXDATA);
  assign stat_wr  = sel && bus_mask_w[0] && (bus_addr[0] == REG_STATUS);
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign drop     = push_req && fifo_full && !fifo_pop;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus_data_w[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A drop on the same edge as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)                                  ovf_d = 1'b1;
    else if (stat_wr && bus_data_w[OVF_CLR_BIT]) ovf_d = 1'b0;
  end

  always_comb begin
    status                        = '0;
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_BUSY]             = (state_q != ST_IDLE);
    status[STAT_OVF]              = ovf_q;
    status[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
    rdata_d = (sel && bus_addr[0] == REG_STATUS) ? status : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_START: tx_q <= 1'b0;
        ST_DATA:  tx_q <= shift_q[0];
        default:  tx_q <= 1'b1;
      endcase
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign bus_data_r = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a transaction-level model of the FIFO, transmitter
// timing and STATUS register, plus a line monitor that decodes 8N1 frames.
module tb_uart_tx_mmio;

  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [29:0] bus_addr = '0;
  logic [31:0] bus_data_w = '0;
  logic [3:0]  bus_mask_w = '0;
  logic [31:0] bus_data_r;
  logic        tx;

  always #5 clock = ~clock;

  uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .sel        (sel),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r),
    .tx         (tx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a queue of pending bytes, the edge at which the
  // transmitter can next take one, and the sticky overflow flag.
  logic [7:0]  mq[$];
  logic [7:0]  exp_tx[$];
  bit          m_ovf = 0;
  int          next_pop = 0;
  logic [31:0] exp_rd = '0;

  always @(posedge clock) begin : model
    bit          pop_now, do_push, drop;
    logic [31:0] st;
    if (!reset) begin
      mq.delete();
      m_ovf    = 0;
      next_pop = 0;
      exp_rd   = '0;
    end else begin
      st        = '0;
      st[0]     = (mq.size() == D);
      st[1]     = (mq.size() == 0);
      st[2]     = (cyc < next_pop);
      st[3]     = m_ovf;
      st[15:8]  = 8'(mq.size());
      exp_rd    = (sel && bus_addr[0]) ? st : 32'h0;
      pop_now   = (mq.size() != 0) && (cyc >= next_pop);
      do_push   = sel && bus_mask_w[0] && !bus_addr[0];
      drop      = do_push && (mq.size() == D) && !pop_now;
      if (pop_now) begin
        exp_tx.push_back(mq.pop_front());
        next_pop = cyc + FRAME + 1;
      end
      if (do_push && !drop) mq.push_back(bus_data_w[7:0]);
      if (drop) m_ovf = 1;
      else if (sel && bus_mask_w[0] && bus_addr[0] && bus_data_w[3]) m_ovf = 0;
    end
    cyc = cyc + 1;
  end

  // Line monitor: sample each bit in its middle, keep frames with a valid stop bit.
  logic [7:0] rx_q[$];
  int         rxt_q[$];

  initial begin : monitor
    logic [7:0] b;
    int         t0;
    logic       stp;
    forever begin
      @(negedge clock);
      if (tx === 1'b0) begin
        t0 = cyc;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clock);
          b[i] = tx;
        end
        repeat (C) @(negedge clock);
        stp = tx;
        if (stp === 1'b1) begin
          rx_q.push_back(b);
          rxt_q.push_back(t0);
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input bit a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; bus_addr = {29'd0, a}; bus_data_w = d; bus_mask_w = m;
    tick(1);
    sel = 1'b0; bus_addr = '0; bus_mask_w = '0;
  endtask

  task automatic bus_read(input bit a, output logic [31:0] v);
    sel = 1'b1; bus_addr = {29'd0, a}; bus_mask_w = '0;
    tick(1);
    v = bus_data_r;
    sel = 1'b0; bus_addr = '0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (!(mq.size() == 0 && cyc > next_pop + 4) && n < 3000) begin
      tick(1);
      n++;
    end
    ok = (n < 3000);
  endtask

  task automatic clear_frames();
    rx_q.delete(); rxt_q.delete(); exp_tx.delete();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tick(1);
    n_checks++;
    if (bus_data_r !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus_data_r); end
    bus_read(1'b1, v);
    n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h expected 00000002", v); end
    bus_read(1'b0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_txdata_read: got %h expected 0", v); end
  endtask

  task automatic test_single();
    logic [7:0]  b = 8'hA5;
    logic        e;
    logic [31:0] v;
    bit          ok;
    bus_write(1'b0, {$urandom_range(0, 32'hFFFFFF), 8'h00} | 32'(b), 4'hF);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_n: got %b expected 1", tx); end
    tick(1);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_n1: got %b expected 1", tx); end
    for (int k = 0; k < FRAME; k++) begin
      tick(1);
      if (k < C)          e = 1'b0;
      else if (k < 9 * C) e = b[(k - C) / C];
      else                e = 1'b1;
      n_checks++;
      if (tx !== e) begin n_fail++; $display("FAIL single_tx_cycle%0d: got %b expected %b", k, tx, e); end
    end
    bus_read(1'b1, v);
    n_checks++;
    if (v !== 32'h2 || v !== exp_rd) begin
      n_fail++; $display("FAIL single_status_after: got %h expected 00000002", v);
    end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout expected idle"); end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      n_fail++; $display("FAIL single_frame: got %0d frames expected 1 frame of a5", rx_q.size());
    end
    clear_frames();
  endtask

  task automatic test_burst();
    logic [31:0] v;
    logic [7:0]  want[3] = '{8'h01, 8'h02, 8'h03};
    bit          ok;
    for (int i = 0; i < 3; i++) bus_write(1'b0, 32'(want[i]), 4'h1);
    bus_read(1'b1, v);
    n_checks++;
    if (v[15:8] !== 8'd2) begin n_fail++; $display("FAIL burst_count: got %0d expected 2", v[15:8]); end
    n_checks++;
    if (v !== exp_rd) begin n_fail++; $display("FAIL burst_status: got %h expected %h", v, exp_rd); end
    drain(ok);
    n_checks++;
    if (!ok || rx_q.size() != 3) begin
      n_fail++; $display("FAIL burst_frames: got %0d expected 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx_q[i] !== want[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %h expected %h", i, rx_q[i], want[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (rxt_q[i+1] - rxt_q[i] != FRAME + 1) begin
          n_fail++; $display("FAIL burst_gap%0d: got %0d expected %0d", i, rxt_q[i+1] - rxt_q[i], FRAME + 1);
        end
      end
    end
    clear_frames();
  endtask

  task automatic test_overflow();
    logic [7:0]  b[6];
    logic [31:0] v;
    bit          ok;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) bus_write(1'b0, 32'(b[i]), 4'h1);
    bus_read(1'b1, v);
    n_checks++;
    if (v !== 32'h0000_040D || v !== exp_rd) begin
      n_fail++; $display("FAIL ovf_status_set: got %h expected 0000040d", v);
    end
    bus_write(1'b1, 32'h8, 4'hF);
    bus_read(1'b1, v);
    n_checks++;
    if (v !== 32'h0000_0405 || v !== exp_rd) begin
      n_fail++; $display("FAIL ovf_status_clear: got %h expected 00000405", v);
    end
    drain(ok);
    n_checks++;
    if (!ok || rx_q.size() != 5) begin
      n_fail++; $display("FAIL ovf_frames: got %0d expected 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (rx_q[i] !== b[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], b[i]); end
      end
    end
    clear_frames();
  endtask

  task automatic test_full_pop_race();
    logic [7:0]  b[6];
    logic [31:0] v;
    bit          ok;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) bus_write(1'b0, 32'(b[i]), 4'h1);
    tick(FRAME - 3);
    bus_write(1'b0, 32'(b[5]), 4'h1);
    bus_read(1'b1, v);
    n_checks++;
    if (v !== 32'h0000_0405 || v !== exp_rd) begin
      n_fail++; $display("FAIL race_status: got %h expected 00000405", v);
    end
    drain(ok);
    n_checks++;
    if (!ok || rx_q.size() != 6) begin
      n_fail++; $display("FAIL race_frames: got %0d expected 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (rx_q[i] !== b[i]) begin n_fail++; $display("FAIL race_byte%0d: got %h expected %h", i, rx_q[i], b[i]); end
      end
    end
    clear_frames();
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 200; i++) begin
      sel        = ($urandom % 4) != 0;
      bus_addr   = {29'd0, ($urandom % 4) == 0};
      bus_mask_w = 4'($urandom);
      bus_data_w = $urandom;
      tick(1);
      n_checks++;
      if (bus_data_r !== exp_rd) begin
        n_fail++; $display("FAIL random_rdata%0d: got %h expected %h", i, bus_data_r, exp_rd);
      end
    end
    sel = 1'b0; bus_mask_w = '0; bus_addr = '0;
    drain(ok);
    n_checks++;
    if (!ok || rx_q.size() != exp_tx.size()) begin
      n_fail++; $display("FAIL random_frames: got %0d expected %0d", rx_q.size(), exp_tx.size());
    end else begin
      for (int i = 0; i < rx_q.size(); i++) begin
        n_checks++;
        if (rx_q[i] !== exp_tx[i]) begin n_fail++; $display("FAIL random_byte%0d: got %h expected %h", i, rx_q[i], exp_tx[i]); end
      end
    end
    clear_frames();
    bus_write(1'b1, 32'h8, 4'h1);
  endtask

  task automatic test_midframe_reset();
    logic [31:0] v;
    bit          ok;
    for (int i = 0; i < 3; i++) bus_write(1'b0, 32'($urandom), 4'h1);
    tick(15);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    bus_read(1'b1, v);
    n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL midrst_status: got %h expected 00000002", v); end
    tick(50);
    clear_frames();
    tick(60);
    n_checks++;
    if (rx_q.size() != 0 || tx !== 1'b1) begin
      n_fail++; $display("FAIL midrst_quiet: got %0d frames expected 0", rx_q.size());
    end
    bus_write(1'b0, 32'h55, 4'h1);
    drain(ok);
    n_checks++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_fail++; $display("FAIL midrst_after: got %0d frames expected 1 frame of 55", rx_q.size());
    end
    clear_frames();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop_race();
    test_random();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
